// File: rtl/mult32x32_seq_pkg.sv
// Shared types and widths for the multiplier request sequencer.
// Operand/product widths, FSM states and request sizing helper.
package mult32x32_seq_pkg;

   localparam int OPND_W = 32;
   localparam int PROD_W = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      ARM   = 2'd2,
      RUN   = 2'd3
   } seq_state_t;

   function automatic int req_bits(input int tag_w);
      return 2 * OPND_W + tag_w;
   endfunction

endpackage

// File: rtl/mult32x32_fast.sv
// Iterative 32x32 unsigned multiplier, one 8-bit slice of b per cycle.
// busy rises the cycle after start and falls with the final product.
module mult32x32_fast (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic [63:0] product
);

   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [1:0]  cnt;
   logic [31:0] b_sh;
   logic [63:0] part;

   assign b_sh = b_q >> {cnt, 3'b000};
   assign part = ({32'd0, a_q} * {56'd0, b_sh[7:0]}) << {cnt, 3'b000};

   // Latch operands on start, then accumulate four partial products.
   always_ff @(posedge clk) begin
      if (!reset) begin
         a_q     <= '0;
         b_q     <= '0;
         cnt     <= '0;
         busy    <= 1'b0;
         product <= '0;
      end else if (start && !busy) begin
         a_q     <= a;
         b_q     <= b;
         cnt     <= '0;
         busy    <= 1'b1;
         product <= '0;
      end else if (busy) begin
         product <= product + part;
         cnt     <= cnt + 2'd1;
         if (cnt == 2'd3) begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/mult32x32_seq_fifo.sv
// First-word-fall-through request FIFO with registered flags.
// Push while full is accepted only when a pop frees the slot.
module mult32x32_seq_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [W-1:0]               wdata,
   input  logic                       pop,
   output logic [W-1:0]               rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic [CNT_W-1:0] cnt_d;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rptr];

   // Next occupancy from the accepted push/pop pair.
   always_comb begin
      cnt_d = count;
      unique case ({do_push, do_pop})
         2'b10:   cnt_d = count + CNT_W'(1);
         2'b01:   cnt_d = count - CNT_W'(1);
         default: cnt_d = count;
      endcase
   end

   // Storage write; entries need no reset since count guards reads.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wptr] <= wdata;
      end
   end

   // Pointers, count and registered full/empty flags.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
      end else begin
         if (do_push) begin
            wptr <= wptr + PTR_W'(1);
         end
         if (do_pop) begin
            rptr <= rptr + PTR_W'(1);
         end
         count <= cnt_d;
         full  <= (cnt_d == CNT_W'(DEPTH));
         empty <= (cnt_d == '0);
      end
   end

endmodule

// File: rtl/mult32x32_seq.sv
// Request sequencer in front of mult32x32_fast: queue, issue, return.
// Holds operands stable through a multiply and buffers one result.
module mult32x32_seq
   import mult32x32_seq_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_a,
   input  logic [31:0]       in_b,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [63:0]       res_product,
   output logic [TAG_W-1:0]  res_tag,
   output logic              mul_start,
   output logic [31:0]       mul_a,
   output logic [31:0]       mul_b,
   input  logic              mul_busy,
   input  logic [63:0]       mul_product,
   output logic              idle
);

   localparam int REQ_W = req_bits(TAG_W);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [OPND_W-1:0] a;
      logic [OPND_W-1:0] b;
      logic [TAG_W-1:0]  tag;
   } req_t;

   seq_state_t       state_q;
   seq_state_t       state_d;
   req_t             wreq;
   req_t             head;
   logic [REQ_W-1:0] head_bits;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   logic             push;
   logic             pop;
   logic             res_take;
   logic             pending;
   logic             capture;
   logic [TAG_W-1:0] op_tag;

   assign wreq.a   = in_a;
   assign wreq.b   = in_b;
   assign wreq.tag = in_tag;
   assign head     = req_t'(head_bits);

   assign in_ready = reset & ~fifo_full;
   assign push     = in_valid & in_ready;
   assign res_take = res_valid & res_ready;
   assign pending  = res_valid & ~res_take;
   assign capture  = (state_q == RUN) & ~mul_busy;

   assign mul_start = (state_q == ISSUE);
   assign idle = (fifo_count == '0) & (state_q == IDLE) & ~res_valid;

   mult32x32_seq_fifo #(
      .DEPTH (DEPTH),
      .W     (REQ_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .wdata (REQ_W'(wreq)),
      .pop   (pop),
      .rdata (head_bits),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Next state and pop decision; a result taken this cycle frees IDLE.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty && !pending) begin
               pop     = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: state_d = ARM;
         ARM: begin
            if (mul_busy) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (!mul_busy) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Operand and tag registers, loaded from the FIFO head on pop.
   always_ff @(posedge clk) begin
      if (!reset) begin
         mul_a  <= '0;
         mul_b  <= '0;
         op_tag <= '0;
      end else if (pop) begin
         mul_a  <= head.a;
         mul_b  <= head.b;
         op_tag <= head.tag;
      end
   end

   // Result register: filled when the multiply ends, held until taken.
   always_ff @(posedge clk) begin
      if (!reset) begin
         res_valid   <= 1'b0;
         res_product <= '0;
         res_tag     <= '0;
      end else if (capture) begin
         res_valid   <= 1'b1;
         res_product <= mul_product;
         res_tag     <= op_tag;
      end else if (res_take) begin
         res_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mult32x32_seq.sv
// Scoreboard bench for mult32x32_seq driving a real mult32x32_fast.
// Expected products come from plain 64-bit arithmetic on the inputs.
module tb_mult32x32_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic [3:0]  in_tag;
   logic        res_valid;
   logic        res_ready;
   logic [63:0] res_product;
   logic [3:0]  res_tag;
   logic        mul_start;
   logic [31:0] mul_a;
   logic [31:0] mul_b;
   logic        mul_busy;
   logic [63:0] mul_product;
   logic        idle;

   typedef struct {
      logic [63:0] prod;
      logic [3:0]  tag;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   logic rnd_rr = 1'b0;

   always #5 clk = ~clk;

   mult32x32_seq #(.DEPTH(4), .TAG_W(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_b        (in_b),
      .in_tag      (in_tag),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_product (res_product),
      .res_tag     (res_tag),
      .mul_start   (mul_start),
      .mul_a       (mul_a),
      .mul_b       (mul_b),
      .mul_busy    (mul_busy),
      .mul_product (mul_product),
      .idle        (idle)
   );

   mult32x32_fast u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (mul_start),
      .a       (mul_a),
      .b       (mul_b),
      .busy    (mul_busy),
      .product (mul_product)
   );

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: accepted request -> expected full-width product.
   always @(negedge clk) begin
      if (reset && in_valid && in_ready) begin
         sb.push_back('{prod: 64'(in_a) * 64'(in_b), tag: in_tag});
      end
   end

   // Monitor: every result handshake is matched against the queue head.
   always @(negedge clk) begin
      if (reset && res_valid && res_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_result", 64'(res_tag), 64'hDEAD);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("product", res_product, e.prod);
            check("tag", 64'(res_tag), 64'(e.tag));
         end
      end
   end

   task automatic push_req(input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] tag);
      int n = 0;
      in_a = a;
      in_b = b;
      in_tag = tag;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 300) begin
         @(posedge clk);
         #1;
         if (rnd_rr) res_ready = 1'($urandom_range(0, 1));
         n++;
         @(negedge clk);
      end
      if (!in_ready) check("push_timeout", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (rnd_rr) res_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      @(negedge clk);
      while (!(idle && sb.size() == 0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check(name, 64'(idle), 64'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [63:0] hold_p;
      logic [3:0]  hold_t;
      logic        ok;
      int          n;

      reset = 1'b0;
      in_valid = 1'b0;
      in_a = '0;
      in_b = '0;
      in_tag = '0;
      res_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_res_valid", 64'(res_valid), 64'd0);
      check("rst_mul_start", 64'(mul_start), 64'd0);
      check("rst_mul_ab", {mul_a, mul_b}, 64'd0);
      check("rst_res_product", res_product, 64'd0);
      check("rst_res_tag", 64'(res_tag), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", 64'(in_ready), 64'd1);
      check("post_rst_idle", 64'(idle), 64'd1);

      // Single request and start latency.
      @(posedge clk);
      #1;
      push_req(32'd3, 32'd5, 4'd1);
      @(negedge clk);
      check("start_cycle1", 64'(mul_start), 64'd0);
      @(negedge clk);
      check("start_cycle2", 64'(mul_start), 64'd1);
      check("start_ops", {mul_a, mul_b}, {32'd3, 32'd5});
      @(negedge clk);
      check("start_pulse_len", 64'(mul_start), 64'd0);
      wait_idle("single_idle");

      // Extreme operands.
      push_req(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2);
      push_req(32'h0001_0000, 32'h0000_FFFF, 4'd3);
      wait_idle("max_idle");

      // Fill: one issued, four queued, producer blocked.
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         push_req($urandom, $urandom, 4'(i));
      end
      @(negedge clk);
      check("full_in_ready", 64'(in_ready), 64'd0);

      // Back-pressure: result frozen, nothing issued.
      n = 0;
      while (!res_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("bp_res_valid", 64'(res_valid), 64'd1);
      hold_p = res_product;
      hold_t = res_tag;
      ok = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (res_product !== hold_p || res_tag !== hold_t) ok = 1'b0;
         if (mul_start !== 1'b0 || in_ready !== 1'b0) ok = 1'b0;
         if (res_valid !== 1'b1) ok = 1'b0;
      end
      check("bp_stable", 64'(ok), 64'd1);
      @(posedge clk);
      #1;
      res_ready = 1'b1;
      wait_idle("full_drain_idle");

      // Push against a full FIFO while it drains, across pointer wrap.
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         push_req($urandom, $urandom, 4'(i + 5));
      end
      @(posedge clk);
      #1;
      res_ready = 1'b1;
      for (int i = 5; i < 10; i++) begin
         push_req($urandom, $urandom, 4'(i + 5));
      end
      wait_idle("wrap_idle");

      // Reset during RUN with three requests queued.
      for (int i = 0; i < 4; i++) begin
         push_req($urandom, $urandom, 4'(i + 8));
      end
      n = 0;
      @(negedge clk);
      while (!mul_busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("mid_busy_seen", 64'(mul_busy), 64'd1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      sb.delete();
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_res_valid", 64'(res_valid), 64'd0);
      check("mid_rst_start_ops", {31'd0, mul_start, mul_a}, 64'd0);
      check("mid_rst_mul_b", 64'(mul_b), 64'd0);
      check("mid_rst_result", {res_product[59:0], res_tag}, 64'd0);
      check("mid_rst_idle", 64'(idle), 64'd1);
      check("mid_rst_in_ready", 64'(in_ready), 64'd1);
      ok = 1'b1;
      repeat (60) begin
         @(negedge clk);
         if (res_valid !== 1'b0 || mul_start !== 1'b0) ok = 1'b0;
      end
      check("mid_rst_no_result", 64'(ok), 64'd1);

      // Random traffic with random consumer stalls.
      rnd_rr = 1'b1;
      for (int i = 0; i < 30; i++) begin
         logic [31:0] ra;
         logic [31:0] rb;
         ra = $urandom;
         rb = $urandom;
         if (i % 7 == 3) ra = 32'hFFFF_FFFF;
         if (i % 5 == 4) rb = 32'd0;
         push_req(ra, rb, 4'($urandom));
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
            res_ready = 1'($urandom_range(0, 1));
         end
      end
      rnd_rr = 1'b0;
      @(posedge clk);
      #1;
      res_ready = 1'b1;
      wait_idle("rand_idle");
      check("sb_empty", 64'(sb.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
